// File: rtl/alu_decode_stage_pkg.sv
// Shared definitions for the ALU decode stage: opcode enum, decoded entry
// payload, skid-buffer state encoding and the instruction decoder.
package alu_decode_stage_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned RA_W    = 3;
  localparam int unsigned RB_W    = 2;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned INSTR_W = 9;

  typedef enum logic [OP_W-1:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    NOT = 4'd5,
    LSH = 4'd6,
    RSH = 4'd7,
    SLT = 4'd8,
    SEQ = 4'd9
  } op_mne;

  localparam logic [OP_W-1:0] kOP_NOP         = 4'hF;
  localparam logic [OP_W-1:0] kOP_ILLEGAL_MIN = 4'd10;

  typedef struct packed {
    op_mne             op;
    logic [RA_W-1:0]   ra;
    logic [RB_W-1:0]   rb;
    logic              use_imm;
    logic [IMM_W-1:0]  imm;
    logic              illegal;
  } dec_entry_t;

  localparam int unsigned DEC_ENTRY_W = $bits(dec_entry_t);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_state_t;

  // Decode one instruction word; NOP filtering is left to the caller.
  function automatic dec_entry_t decode(input logic [INSTR_W-1:0] instr);
    dec_entry_t e;
    logic [OP_W-1:0] opc;
    e   = '0;
    opc = instr[8:5];
    if (opc >= kOP_ILLEGAL_MIN) begin
      e.illegal = 1'b1;
    end else begin
      e.op = op_mne'(opc);
      e.ra = instr[4:2];
      case (e.op)
        NOT: ;
        LSH, RSH: begin
          e.use_imm = 1'b1;
          e.imm     = IMM_W'(instr[1:0]) + IMM_W'(1);
        end
        default: e.rb = instr[1:0];
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/alu_decode_stage_skid.sv
// Two-entry skid buffer with valid/ready on both sides.
// Ports: clk, rst (async high), flush (drop contents), in_valid/in_ready/in_data
// upstream, out_valid/out_ready/out_data downstream. in_ready and out_valid are
// registered; out_data is held stable while out_valid & !out_ready.
module alu_skid_buffer
  import alu_decode_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state, state_nx;
  logic [WIDTH-1:0] skid_data;
  logic             in_xfer, out_xfer;
  logic             load_out, load_skid, move_skid;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Next-state and data-path steering.
  always_comb begin
    state_nx  = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      S_EMPTY: begin
        if (in_xfer) begin
          state_nx = S_ONE;
          load_out = 1'b1;
        end
      end
      S_ONE: begin
        if (in_xfer && !out_xfer) begin
          state_nx  = S_TWO;
          load_skid = 1'b1;
        end else if (out_xfer && !in_xfer) begin
          state_nx = S_EMPTY;
        end else if (in_xfer && out_xfer) begin
          load_out = 1'b1;
        end
      end
      S_TWO: begin
        if (out_xfer) begin
          state_nx  = S_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_nx = S_EMPTY;
    endcase
    if (flush) begin
      state_nx  = S_EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  // State, registered handshake flags and entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx != S_TWO);
      out_valid <= (state_nx != S_EMPTY);
      if (load_out) begin
        out_data <= in_data;
      end else if (move_skid) begin
        out_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode/issue stage feeding the ALU: decodes 9-bit instructions, drops NOPs,
// flags and counts illegal opcodes, and buffers results in a 2-entry skid.
// Ports: Clk, Reset (async high), Flush; upstream InValid/InReady/Instr/PcIn;
// downstream OutValid/OutReady with AluOp, RegA, RegB, UseImm, Imm, Illegal,
// PcOut; IllegalCount is a saturating count of accepted illegal instructions.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
#(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Flush,
  input  logic               InValid,
  output logic               InReady,
  input  logic [INSTR_W-1:0] Instr,
  input  logic [PC_W-1:0]    PcIn,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [OP_W-1:0]    AluOp,
  output logic [RA_W-1:0]    RegA,
  output logic [RB_W-1:0]    RegB,
  output logic               UseImm,
  output logic [IMM_W-1:0]   Imm,
  output logic               Illegal,
  output logic [PC_W-1:0]    PcOut,
  output logic [CNT_W-1:0]   IllegalCount
);

  localparam int unsigned PAYLOAD_W = PC_W + DEC_ENTRY_W;

  dec_entry_t           dec_c;
  dec_entry_t           out_entry;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 is_nop;
  logic                 skid_in_valid;
  logic                 accept;

  assign dec_c  = decode(Instr);
  assign is_nop = (Instr[8:5] == kOP_NOP);

  // NOPs are consumed without entering the buffer; flush discards the input.
  assign skid_in_valid = InValid & ~is_nop & ~Flush;
  assign accept        = InValid & InReady & ~Flush;

  alu_skid_buffer #(
    .WIDTH(PAYLOAD_W)
  ) u_skid (
    .clk      (Clk),
    .rst      (Reset),
    .flush    (Flush),
    .in_valid (skid_in_valid),
    .in_ready (InReady),
    .in_data  ({PcIn, dec_c}),
    .out_valid(OutValid),
    .out_ready(OutReady),
    .out_data (out_payload)
  );

  assign {PcOut, out_entry} = out_payload;
  assign AluOp   = out_entry.op;
  assign RegA    = out_entry.ra;
  assign RegB    = out_entry.rb;
  assign UseImm  = out_entry.use_imm;
  assign Imm     = out_entry.imm;
  assign Illegal = out_entry.illegal;

  // Saturating illegal-opcode counter; survives flush.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      IllegalCount <= '0;
    end else if (accept && !is_nop && dec_c.illegal && (IllegalCount != '1)) begin
      IllegalCount <= IllegalCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed instructions push hand-computed
// entries into a queue; a monitor pops and compares on every output transfer.
module tb_alu_decode_stage;
  import alu_decode_stage_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset, Flush, InValid, OutReady;
  logic [8:0] Instr;
  logic [9:0] PcIn;
  logic       InReady, OutValid, UseImm, Illegal;
  logic [3:0] AluOp;
  logic [2:0] RegA;
  logic [1:0] RegB;
  logic [7:0] Imm;
  logic [9:0] PcOut;
  logic [7:0] IllegalCount;

  logic       s_InReady, s_OutValid, s_UseImm, s_Illegal;
  logic [3:0] s_AluOp;
  logic [2:0] s_RegA;
  logic [1:0] s_RegB;
  logic [7:0] s_Imm;
  logic [9:0] s_PcOut;
  logic [1:0] s_IllegalCount;

  always #5 Clk = ~Clk;

  alu_decode_stage #(.PC_W(10), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .Instr(Instr), .PcIn(PcIn), .OutValid(OutValid), .OutReady(OutReady),
    .AluOp(AluOp), .RegA(RegA), .RegB(RegB), .UseImm(UseImm), .Imm(Imm),
    .Illegal(Illegal), .PcOut(PcOut), .IllegalCount(IllegalCount)
  );

  alu_decode_stage #(.PC_W(10), .CNT_W(2)) u_sat (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(s_InReady),
    .Instr(Instr), .PcIn(PcIn), .OutValid(s_OutValid), .OutReady(OutReady),
    .AluOp(s_AluOp), .RegA(s_RegA), .RegB(s_RegB), .UseImm(s_UseImm), .Imm(s_Imm),
    .Illegal(s_Illegal), .PcOut(s_PcOut), .IllegalCount(s_IllegalCount)
  );

  typedef struct packed {
    dec_entry_t e;
    logic [9:0] pc;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  function automatic exp_t mk(input op_mne op, input logic [2:0] ra, input logic [1:0] rb,
                              input logic ui, input logic [7:0] imm, input logic ill,
                              input logic [9:0] pc);
    exp_t x;
    x.e.op = op; x.e.ra = ra; x.e.rb = rb; x.e.use_imm = ui;
    x.e.imm = imm; x.e.illegal = ill; x.pc = pc;
    return x;
  endfunction

  // Monitor: every output transfer must match the oldest expected entry.
  always @(negedge Clk) begin
    if (!Reset && OutValid && OutReady) begin
      if (q.size() == 0) begin
        check("unexpected_out", {3'b0, AluOp, RegA, RegB, UseImm, Imm, Illegal, PcOut}, 32'hFFFF_FFFF);
      end else begin
        exp_t x;
        x = q.pop_front();
        check("entry", {3'b0, AluOp, RegA, RegB, UseImm, Imm, Illegal, PcOut}, {3'b0, x});
      end
    end
  end

  // Present one instruction until accepted; expected entry queued on acceptance.
  task automatic send(input logic [8:0] ins, input logic [9:0] pc, input logic push, input exp_t x);
    bit acc = 0;
    int t = 0;
    InValid = 1'b1; Instr = ins; PcIn = pc;
    while (!acc && t < 40) begin
      @(negedge Clk);
      acc = InReady;
      @(posedge Clk);
      t++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    else if (push) q.push_back(x);
    #1 InValid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge Clk);
      t++;
    end
    check("drain_left", q.size(), 0);
    @(posedge Clk); #1;
  endtask

  exp_t none;

  initial begin
    none = '0;
    Reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1; Instr = '0; PcIn = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_outvalid", OutValid, 0);
    check("rst_inready", InReady, 1);
    check("rst_aluop", AluOp, 0);
    check("rst_count", IllegalCount, 0);
    check("rst_sat_count", s_IllegalCount, 0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // 1: streaming ADD, SUB, XOR
    send(9'b0000_001_10, 10'd1, 1, mk(ADD, 3'd1, 2'd2, 0, 8'd0, 0, 10'd1));
    check("latency_1cycle", OutValid, 1);
    send(9'b0001_011_01, 10'd2, 1, mk(SUB, 3'd3, 2'd1, 0, 8'd0, 0, 10'd2));
    send(9'b0100_111_11, 10'd3, 1, mk(XOR, 3'd7, 2'd3, 0, 8'd0, 0, 10'd3));
    drain();

    // 2: backpressure, skid fills, third held upstream
    OutReady = 1'b0;
    send(9'b0010_100_00, 10'd10, 1, mk(AND, 3'd4, 2'd0, 0, 8'd0, 0, 10'd10));
    send(9'b0011_010_01, 10'd11, 1, mk(OR, 3'd2, 2'd1, 0, 8'd0, 0, 10'd11));
    check("full_inready", InReady, 0);
    fork
      send(9'b0101_110_11, 10'd12, 1, mk(NOT, 3'd6, 2'd0, 0, 8'd0, 0, 10'd12));
      begin
        repeat (3) @(negedge Clk);
        check("held_inready", InReady, 0);
        check("held_aluop", AluOp, 4'd2);
        check("held_pc", PcOut, 10'd10);
        @(posedge Clk); #1 OutReady = 1'b1;
      end
    join
    drain();

    // 3: shifts and compares
    send(9'b0110_010_11, 10'd20, 1, mk(LSH, 3'd2, 2'd0, 1, 8'd4, 0, 10'd20));
    send(9'b0111_001_00, 10'd21, 1, mk(RSH, 3'd1, 2'd0, 1, 8'd1, 0, 10'd21));
    send(9'b1000_101_10, 10'd22, 1, mk(SLT, 3'd5, 2'd2, 0, 8'd0, 0, 10'd22));
    send(9'b1001_000_01, 10'd23, 1, mk(SEQ, 3'd0, 2'd1, 0, 8'd0, 0, 10'd23));
    drain();

    // 4: NOP dropped, illegals flagged and counted, small counter saturates
    send(9'b1111_000_00, 10'd30, 0, none);
    check("nop_no_out", OutValid, 0);
    check("nop_not_counted", IllegalCount, 0);
    send(9'b1100_011_10, 10'd31, 1, mk(ADD, 3'd0, 2'd0, 0, 8'd0, 1, 10'd31));
    check("illegal_count1", IllegalCount, 1);
    send(9'b1010_001_01, 10'd32, 1, mk(ADD, 3'd0, 2'd0, 0, 8'd0, 1, 10'd32));
    send(9'b1011_111_11, 10'd33, 1, mk(ADD, 3'd0, 2'd0, 0, 8'd0, 1, 10'd33));
    send(9'b1101_000_00, 10'd34, 1, mk(ADD, 3'd0, 2'd0, 0, 8'd0, 1, 10'd34));
    send(9'b1110_010_10, 10'd35, 1, mk(ADD, 3'd0, 2'd0, 0, 8'd0, 1, 10'd35));
    check("illegal_count5", IllegalCount, 5);
    check("sat_count3", s_IllegalCount, 3);
    drain();

    // 5: flush while full with an illegal instruction offered
    OutReady = 1'b0;
    send(9'b0001_001_01, 10'd40, 1, mk(SUB, 3'd1, 2'd1, 0, 8'd0, 0, 10'd40));
    send(9'b0010_010_10, 10'd41, 1, mk(AND, 3'd2, 2'd2, 0, 8'd0, 0, 10'd41));
    InValid = 1'b1; Instr = 9'b1010_000_00; PcIn = 10'd42; Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0; InValid = 1'b0;
    q.delete();
    check("flush_outvalid", OutValid, 0);
    check("flush_inready", InReady, 1);
    check("flush_count_kept", IllegalCount, 5);
    OutReady = 1'b1;
    repeat (3) @(posedge Clk);
    #1;

    // 6: reset while full
    OutReady = 1'b0;
    send(9'b0000_100_01, 10'd50, 1, mk(ADD, 3'd4, 2'd1, 0, 8'd0, 0, 10'd50));
    send(9'b0100_011_10, 10'd51, 1, mk(XOR, 3'd3, 2'd2, 0, 8'd0, 0, 10'd51));
    @(posedge Clk); #2 Reset = 1'b1;
    #1;
    q.delete();
    check("mid_rst_outvalid", OutValid, 0);
    check("mid_rst_inready", InReady, 1);
    check("mid_rst_pc", PcOut, 0);
    check("mid_rst_count", IllegalCount, 0);
    check("mid_rst_sat_count", s_IllegalCount, 0);
    @(posedge Clk); #1 Reset = 1'b0; OutReady = 1'b1;
    send(9'b1001_110_10, 10'd60, 1, mk(SEQ, 3'd6, 2'd2, 0, 8'd0, 0, 10'd60));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
